micro_waves_control_param: RTL and testbench

Parametrised next-generation microwave oven controller: one-hot keypad entry of an mm:ss cook time with right-shift digit entry, BCD countdown at a prescaled one-second tick, door interlock, pause/resume, and a selectable power level that duty-cycles the magnetron over a 10-second window. It drives seven-segment digits and `mag_on` directly and replaces the fixed single-minute-digit controller at the top of the oven design.

---
 rtl/micro_waves_control_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_micro_waves_control_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_waves_control_param.sv
// Microwave oven controller: keypad mm:ss entry, BCD countdown on a prescaled
// one-second tick, door interlock, pause/resume and power-level duty cycling.
module micro_waves_control_param #(
    parameter int CLK_DIV    = 100,
    parameter int MIN_DIGITS = 1
) (
    input  logic                      clk,
    input  logic                      clearn,
    input  logic [9:0]                keypad,
    input  logic                      startn,
    input  logic                      stopn,
    input  logic                      powern,
    input  logic                      door_closed,
    output logic [6:0]                sec_ones_segs,
    output logic [6:0]                sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0]   min_segs,
    output logic                      mag_on,
    output logic                      done,
    output logic [3:0]                power_level
);

    // state      | meaning
    // S_IDLE     | digit entry, waiting for start
    // S_POWER_SET| next key press selects the power level
    // S_COOK     | counting down, magnetron duty-cycled
    // S_PAUSE    | door opened or stop pressed, everything frozen
    // S_DONE     | countdown reached 0:00
    typedef enum logic [2:0] {
        S_IDLE,
        S_POWER_SET,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    state_t                       r_state, w_state;
    logic                         r_startn, r_startn_d, r_stopn, r_stopn_d;
    logic                         r_powern, r_powern_d;
    logic [9:0]                   r_key, r_key_d;
    logic [3:0]                   r_ones, r_tens, w_ones, w_tens;
    logic [MIN_DIGITS-1:0][3:0]   r_min, w_min;
    logic [3:0]                   r_power, w_power;
    logic [PW-1:0]                r_presc, w_presc;
    logic [3:0]                   r_elapsed, w_elapsed;

    logic                         w_start_ev, w_stop_ev, w_power_ev, w_key_ev;
    logic                         w_key_onehot, w_time_nz, w_tick;
    logic [3:0]                   w_key_digit;
    logic [3:0]                   w_dec_ones, w_dec_tens;
    logic [MIN_DIGITS-1:0][3:0]   w_dec_min, w_shift_min;
    logic                         w_dec_zero, w_borrow;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Two register stages per key: an event is a registered 1->0 (or 0->one-hot) transition.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_startn   <= 1'b1;
            r_startn_d <= 1'b1;
            r_stopn    <= 1'b1;
            r_stopn_d  <= 1'b1;
            r_powern   <= 1'b1;
            r_powern_d <= 1'b1;
            r_key      <= '0;
            r_key_d    <= '0;
        end else begin
            r_startn   <= startn;
            r_startn_d <= r_startn;
            r_stopn    <= stopn;
            r_stopn_d  <= r_stopn;
            r_powern   <= powern;
            r_powern_d <= r_powern;
            r_key      <= keypad;
            r_key_d    <= r_key;
        end
    end

    assign w_start_ev   = r_startn_d & ~r_startn;
    assign w_stop_ev    = r_stopn_d & ~r_stopn;
    assign w_power_ev   = r_powern_d & ~r_powern;
    assign w_key_onehot = (r_key != 10'd0) && ((r_key & (r_key - 10'd1)) == 10'd0);
    assign w_key_ev     = (r_key_d == 10'd0) && w_key_onehot;
    assign w_time_nz    = (r_ones != 4'd0) || (r_tens != 4'd0) || (r_min != '0);
    assign w_tick       = (r_presc == PRESC_LAST);

    always_comb begin
        w_key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_key[i]) w_key_digit = 4'(i);
        end
    end

    always_comb begin
        w_shift_min    = r_min;
        w_shift_min[0] = r_tens;
        for (int i = 1; i < MIN_DIGITS; i++) begin
            w_shift_min[i] = r_min[i-1];
        end
    end

    // Seconds borrow from minutes as 59; seconds above 59 count down as entered.
    always_comb begin
        w_dec_ones = r_ones;
        w_dec_tens = r_tens;
        w_dec_min  = r_min;
        w_borrow   = 1'b0;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_tens = r_tens - 4'd1;
            w_dec_ones = 4'd9;
        end else begin
            w_dec_tens = 4'd5;
            w_dec_ones = 4'd9;
            w_borrow   = 1'b1;
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (w_borrow) begin
                    if (r_min[i] != 4'd0) begin
                        w_dec_min[i] = r_min[i] - 4'd1;
                        w_borrow     = 1'b0;
                    end else begin
                        w_dec_min[i] = 4'd9;
                    end
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_min == '0);

    always_comb begin
        w_state   = r_state;
        w_ones    = r_ones;
        w_tens    = r_tens;
        w_min     = r_min;
        w_power   = r_power;
        w_presc   = r_presc;
        w_elapsed = r_elapsed;
        case (r_state)
            S_IDLE: begin
                if (w_stop_ev) begin
                    w_ones  = 4'd0;
                    w_tens  = 4'd0;
                    w_min   = '0;
                    w_power = 4'd10;
                end else if (w_start_ev && door_closed && w_time_nz) begin
                    w_state   = S_COOK;
                    w_presc   = '0;
                    w_elapsed = 4'd0;
                end else if (w_power_ev) begin
                    w_state = S_POWER_SET;
                end else if (w_key_ev) begin
                    w_ones = w_key_digit;
                    w_tens = r_ones;
                    w_min  = w_shift_min;
                end
            end
            S_POWER_SET: begin
                if (w_stop_ev) begin
                    w_state = S_IDLE;
                end else if (w_key_ev) begin
                    w_power = (w_key_digit == 4'd0) ? 4'd10 : w_key_digit;
                    w_state = S_IDLE;
                end
            end
            S_COOK: begin
                // Pause wins over a coincident tick; the prescaler holds its phase.
                if (w_stop_ev || !door_closed) begin
                    w_state = S_PAUSE;
                end else begin
                    w_presc = w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        w_ones    = w_dec_ones;
                        w_tens    = w_dec_tens;
                        w_min     = w_dec_min;
                        w_elapsed = (r_elapsed == 4'd9) ? 4'd0 : r_elapsed + 4'd1;
                        if (w_dec_zero) w_state = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (w_stop_ev) begin
                    w_state = S_IDLE;
                    w_ones  = 4'd0;
                    w_tens  = 4'd0;
                    w_min   = '0;
                end else if (w_start_ev && door_closed) begin
                    w_state = S_COOK;
                end
            end
            S_DONE: begin
                if (w_key_ev || w_start_ev || w_stop_ev || !door_closed) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state   <= S_IDLE;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_min     <= '0;
            r_power   <= 4'd10;
            r_presc   <= '0;
            r_elapsed <= 4'd0;
        end else begin
            r_state   <= w_state;
            r_ones    <= w_ones;
            r_tens    <= w_tens;
            r_min     <= w_min;
            r_power   <= w_power;
            r_presc   <= w_presc;
            r_elapsed <= w_elapsed;
        end
    end

    always_comb begin
        min_segs = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            min_segs[7*i +: 7] = seg7(r_min[i]);
        end
    end

    assign sec_ones_segs = seg7(r_ones);
    assign sec_tens_segs = seg7(r_tens);
    assign mag_on        = (r_state == S_COOK) && door_closed && (r_elapsed < r_power);
    assign done          = (r_state == S_DONE);
    assign power_level   = r_power;

endmodule

// File: tb/tb_micro_waves_control_param.sv
// Bench for micro_waves_control_param: table-driven vectors through an expected-value
// queue, plus hand-written pause/resume and reset-mid-cook sequences.
module tb_micro_waves_control_param;

    localparam int CLK_DIV = 4;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;

    localparam int OP_NOP = 0, OP_KEY = 1, OP_START = 2, OP_STOP = 3, OP_POWER = 4;
    localparam int OP_DOOR = 5, OP_WAIT = 6, OP_MULTI = 7, OP_STOPSTART = 8;

    typedef struct {
        int         op;
        int         arg;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] mn;
        logic [13:0] mn2;
        logic       mag;
        logic       dn;
        logic [3:0] pwr;
    } vec_t;

    logic        clk, clearn, startn, stopn, powern, door_closed;
    logic [9:0]  keypad;
    logic [6:0]  ones1, tens1, min1, ones2, tens2;
    logic [13:0] min2;
    logic        mag1, done1, mag2, done2;
    logic [3:0]  pwr1, pwr2;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    micro_waves_control_param #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(1)) dut1 (
        .clk(clk), .clearn(clearn), .keypad(keypad), .startn(startn), .stopn(stopn),
        .powern(powern), .door_closed(door_closed), .sec_ones_segs(ones1),
        .sec_tens_segs(tens1), .min_segs(min1), .mag_on(mag1), .done(done1),
        .power_level(pwr1));

    micro_waves_control_param #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(2)) dut2 (
        .clk(clk), .clearn(clearn), .keypad(keypad), .startn(startn), .stopn(stopn),
        .powern(powern), .door_closed(door_closed), .sec_ones_segs(ones2),
        .sec_tens_segs(tens2), .min_segs(min2), .mag_on(mag2), .done(done2),
        .power_level(pwr2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic add(input int op, input int arg, input logic [6:0] o, input logic [6:0] t,
                       input logic [6:0] m, input logic [13:0] m2, input logic mg,
                       input logic dn, input logic [3:0] pw);
        vec_t v;
        v.op = op; v.arg = arg; v.ones = o; v.tens = t; v.mn = m; v.mn2 = m2;
        v.mag = mg; v.dn = dn; v.pwr = pw;
        vecs.push_back(v);
    endtask

    task automatic cmp(input int idx, input string f, input logic [13:0] act,
                       input logic [13:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL step%0d %s got %h want %h", idx, f, act, exp);
    endtask

    task automatic check_pop(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL step%0d scoreboard empty got 0 want 1", idx);
            return;
        end
        e = exp_q.pop_front();
        cmp(idx, "ones",  {7'd0, ones1}, {7'd0, e.ones});
        cmp(idx, "tens",  {7'd0, tens1}, {7'd0, e.tens});
        cmp(idx, "min",   {7'd0, min1},  {7'd0, e.mn});
        cmp(idx, "min2",  min2,          e.mn2);
        cmp(idx, "mag",   {13'd0, mag1}, {13'd0, e.mag});
        cmp(idx, "done",  {13'd0, done1}, {13'd0, e.dn});
        cmp(idx, "power", {10'd0, pwr1}, {10'd0, e.pwr});
    endtask

    // Hand-sequence check: minutes and tens expected 0.
    task automatic chk(input int idx, input logic [6:0] o, input logic mg, input logic dn,
                       input logic [3:0] pw);
        vec_t e;
        e.op = OP_NOP; e.arg = 0; e.ones = o; e.tens = S0; e.mn = S0; e.mn2 = {S0, S0};
        e.mag = mg; e.dn = dn; e.pwr = pw;
        exp_q.push_back(e);
        check_pop(idx);
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int d);
        keypad = 10'd1 << d;
        tick_wait(1);
        keypad = 10'd0;
        tick_wait(1);
    endtask

    task automatic pulse(input logic s, input logic p, input logic st);
        startn = ~s; stopn = ~st; powern = ~p;
        tick_wait(1);
        startn = 1'b1; stopn = 1'b1; powern = 1'b1;
        tick_wait(1);
    endtask

    task automatic apply(input vec_t v);
        case (v.op)
            OP_KEY:       press(v.arg);
            OP_START:     pulse(1'b1, 1'b0, 1'b0);
            OP_STOP:      pulse(1'b0, 1'b0, 1'b1);
            OP_POWER:     pulse(1'b0, 1'b1, 1'b0);
            OP_STOPSTART: pulse(1'b1, 1'b0, 1'b1);
            OP_DOOR:      door_closed = v.arg[0];
            OP_WAIT:      tick_wait(v.arg);
            OP_MULTI: begin
                keypad = 10'b00_0000_0011;
                tick_wait(1);
                keypad = 10'd0;
                tick_wait(1);
            end
            default: ;
        endcase
    endtask

    initial begin
        clearn = 1'b0; startn = 1'b1; stopn = 1'b1; powern = 1'b1;
        door_closed = 1'b0; keypad = 10'd0;

        add(OP_NOP,   0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   2, S2, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   5, S5, S2, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   9, S9, S5, S2, {S0, S2}, 0, 0, 10);
        add(OP_KEY,   9, S9, S9, S5, {S2, S5}, 0, 0, 10);
        add(OP_KEY,   9, S9, S9, S9, {S5, S9}, 0, 0, 10);
        add(OP_MULTI, 0, S9, S9, S9, {S5, S9}, 0, 0, 10);
        add(OP_DOOR,  1, S9, S9, S9, {S5, S9}, 0, 0, 10);
        add(OP_STOPSTART, 0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_WAIT,  8, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_DOOR,  0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   3, S3, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_START, 0, S3, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_WAIT,  8, S3, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_DOOR,  1, S3, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_START, 0, S3, S0, S0, {S0, S0}, 1, 0, 10);
        add(OP_WAIT,  CLK_DIV, S2, S0, S0, {S0, S0}, 1, 0, 10);
        add(OP_WAIT,  2*CLK_DIV, S0, S0, S0, {S0, S0}, 0, 1, 10);
        add(OP_KEY,   1, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   1, S1, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   0, S0, S1, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   0, S0, S0, S1, {S0, S1}, 0, 0, 10);
        add(OP_START, 0, S0, S0, S1, {S0, S1}, 1, 0, 10);
        add(OP_WAIT,  CLK_DIV, S9, S5, S0, {S0, S0}, 1, 0, 10);
        add(OP_WAIT,  CLK_DIV, S8, S5, S0, {S0, S0}, 1, 0, 10);
        add(OP_STOP,  0, S8, S5, S0, {S0, S0}, 0, 0, 10);
        add(OP_STOP,  0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_POWER, 0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   3, S0, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_KEY,   1, S1, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_KEY,   2, S2, S1, S0, {S0, S0}, 0, 0, 3);
        add(OP_START, 0, S2, S1, S0, {S0, S0}, 1, 0, 3);
        add(OP_WAIT,  2*CLK_DIV, S0, S1, S0, {S0, S0}, 1, 0, 3);
        add(OP_WAIT,  CLK_DIV, S9, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_WAIT,  7*CLK_DIV, S2, S0, S0, {S0, S0}, 1, 0, 3);
        add(OP_WAIT,  2*CLK_DIV, S0, S0, S0, {S0, S0}, 0, 1, 3);
        add(OP_STOP,  0, S0, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_POWER, 0, S0, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_STOP,  0, S0, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_POWER, 0, S0, S0, S0, {S0, S0}, 0, 0, 3);
        add(OP_KEY,   0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_POWER, 0, S0, S0, S0, {S0, S0}, 0, 0, 10);
        add(OP_KEY,   4, S0, S0, S0, {S0, S0}, 0, 0, 4);
        add(OP_STOP,  0, S0, S0, S0, {S0, S0}, 0, 0, 10);

        #23 clearn = 1'b1;
        tick_wait(1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            check_pop(i);
        end

        // Pause via door open keeps digits and prescaler phase; resume continues it.
        door_closed = 1'b1;
        press(9);
        pulse(1'b1, 1'b0, 1'b0);
        tick_wait(CLK_DIV + 2);
        chk(100, S8, 1, 0, 10);
        door_closed = 1'b0;
        #2;
        chk(101, S8, 0, 0, 10);
        tick_wait(1);
        tick_wait(5);
        chk(102, S8, 0, 0, 10);
        door_closed = 1'b1;
        #2;
        chk(103, S8, 0, 0, 10);
        pulse(1'b1, 1'b0, 1'b0);
        chk(104, S8, 1, 0, 10);
        tick_wait(CLK_DIV - 3);
        chk(105, S8, 1, 0, 10);
        tick_wait(1);
        chk(106, S7, 1, 0, 10);
        pulse(1'b0, 1'b0, 1'b1);
        chk(107, S7, 0, 0, 10);
        pulse(1'b0, 1'b0, 1'b1);
        chk(108, S0, 0, 0, 10);

        // Asynchronous reset in the middle of a cook.
        pulse(1'b0, 1'b1, 1'b0);
        press(5);
        press(5);
        chk(110, S5, 0, 0, 5);
        pulse(1'b1, 1'b0, 1'b0);
        tick_wait(2);
        chk(111, S5, 1, 0, 5);
        #2 clearn = 1'b0;
        #1;
        chk(112, S0, 0, 0, 10);
        clearn = 1'b1;
        tick_wait(2*CLK_DIV);
        chk(113, S0, 0, 0, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
